// File: rtl/fetch_pkg.sv
// fetch_pkg
// Shared definitions for the buffered instruction-fetch stage: the request
// tracking state encoding and the default values of the stage parameters.
package fetch_pkg;

    // Request tracking state:
    //   IDLE - no memory request outstanding
    //   WAIT - one request outstanding, its response will be enqueued
    //   DROP - one request outstanding, its response will be discarded
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } fetch_state_e;

    localparam int DEF_ADDR_W   = 16;
    localparam int DEF_INSTR_W  = 16;
    localparam int DEF_PC_INC   = 2;
    localparam int DEF_RESET_PC = 0;
    localparam int DEF_DEPTH    = 4;

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo
// Synchronous DEPTH-entry FIFO holding fetched {instruction, pc} entries.
// DEPTH must be a power of two (>= 2) so the pointers wrap naturally.
//
// Ports:
//   clk          in   rising-edge clock
//   rst          in   asynchronous active-high reset (empties the FIFO)
//   push_i       in   write push_data_i at the tail
//   push_data_i  in   entry to write
//   pop_i        in   remove the head entry (ignored when empty)
//   flush_i      in   discard all entries; dominates push and pop
//   head_valid_o out  FIFO holds at least one entry
//   head_data_o  out  head entry (meaningless while head_valid_o = 0)
//   count_o      out  number of stored entries (0..DEPTH)
module fetch_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push_i,
    input  logic [WIDTH-1:0]       push_data_i,
    input  logic                   pop_i,
    input  logic                   flush_i,
    output logic                   head_valid_o,
    output logic [WIDTH-1:0]       head_data_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign do_push = push_i & ~full & ~flush_i;
    assign do_pop  = pop_i & (count_q != '0) & ~flush_i;

    // Pointer and occupancy update; a simultaneous push and pop leaves the
    // count unchanged.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            if (do_push && !do_pop) begin
                count_d = count_q + CNT_W'(1);
            end else if (!do_push && do_pop) begin
                count_d = count_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only visible once counted.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign head_valid_o = (count_q != '0);
    assign head_data_o  = mem_q[rd_ptr_q];
    assign count_o      = count_q;

    // The issue credit rule upstream must keep pushes away from a full FIFO.
    pushNotFull: assert property (@(posedge clk) disable iff (rst) !(push_i && full));

endmodule

// File: rtl/fetch_buf.sv
// fetch_buf
// Buffered instruction-fetch stage. Keeps the PC, issues at most one request
// to instruction memory at a time, tags each response with the address it
// was fetched from and queues it towards decode. A redirect reloads the PC,
// flushes the queue and turns an outstanding request into one whose response
// is discarded.
//
// Ports:
//   clk, rst        clock (rising edge), asynchronous active-high reset
//   halt_df         stop issuing new fetches; queued entries still drain
//   redirect_valid  load redirect_pc into the PC and flush the queue
//   redirect_pc     redirect target address
//   imem_req_valid  request to instruction memory (combinational)
//   imem_req_ready  memory accepts the request
//   imem_addr       request address (current PC)
//   imem_rsp_valid  response valid, in order, at least one cycle after accept
//   imem_rsp_data   fetched instruction
//   instr_valid     queue head valid towards decode
//   instr_ready     decode consumes the head
//   instr_fd        head instruction
//   pc_fd           head instruction address
//   pcinc_fd        pc_fd + PC_INC (modulo 2^ADDR_W)
module fetch_buf
    import fetch_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int INSTR_W  = DEF_INSTR_W,
    parameter int PC_INC   = DEF_PC_INC,
    parameter int RESET_PC = DEF_RESET_PC,
    parameter int DEPTH    = DEF_DEPTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               halt_df,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               imem_req_valid,
    input  logic               imem_req_ready,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_rsp_valid,
    input  logic [INSTR_W-1:0] imem_rsp_data,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [INSTR_W-1:0] instr_fd,
    output logic [ADDR_W-1:0]  pc_fd,
    output logic [ADDR_W-1:0]  pcinc_fd
);

    localparam int CNT_W   = $clog2(DEPTH) + 1;
    localparam int ENTRY_W = INSTR_W + ADDR_W;
    localparam logic [ADDR_W-1:0] PC_STEP  = ADDR_W'(PC_INC);
    localparam logic [ADDR_W-1:0] PC_RESET = ADDR_W'(RESET_PC);

    fetch_state_e        state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [ADDR_W-1:0]   pend_pc_q, pend_pc_d;

    logic                has_credit;
    logic                accept;
    logic                push;
    logic                pop;
    logic                head_valid;
    logic [ENTRY_W-1:0]  head_data;
    logic [CNT_W-1:0]    fifo_count;

    // A free queue slot is reserved for every issued request, so a response
    // can always be enqueued without back-pressuring memory.
    assign has_credit     = (fifo_count < CNT_W'(DEPTH));
    assign imem_req_valid = ~rst & (state_q == IDLE) & ~halt_df & ~redirect_valid & has_credit;
    assign imem_addr      = pc_q;
    assign accept         = imem_req_valid & imem_req_ready;
    assign pop            = head_valid & instr_ready;

    // Next-state logic. A redirect overrides everything else in the cycle:
    // any response arriving with it is discarded, and a request still in
    // flight is marked for dropping. If the in-flight response arrives in the
    // redirect cycle itself, nothing is left outstanding, hence IDLE.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        pend_pc_d = pend_pc_q;
        push      = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d   = WAIT;
                    pc_d      = pc_q + PC_STEP;
                    pend_pc_d = pc_q;
                end
            end
            WAIT: begin
                if (imem_rsp_valid) begin
                    push    = 1'b1;
                    state_d = IDLE;
                end
            end
            DROP: begin
                if (imem_rsp_valid) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (redirect_valid) begin
            pc_d = redirect_pc;
            push = 1'b0;
            if (state_q != IDLE) begin
                state_d = imem_rsp_valid ? IDLE : DROP;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            pc_q      <= PC_RESET;
            pend_pc_q <= PC_RESET;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            pend_pc_q <= pend_pc_d;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk          (clk),
        .rst          (rst),
        .push_i       (push),
        .push_data_i  ({imem_rsp_data, pend_pc_q}),
        .pop_i        (pop),
        .flush_i      (redirect_valid),
        .head_valid_o (head_valid),
        .head_data_o  (head_data),
        .count_o      (fifo_count)
    );

    assign instr_valid = head_valid;
    assign instr_fd    = head_data[ADDR_W +: INSTR_W];
    assign pc_fd       = head_data[ADDR_W-1:0];
    assign pcinc_fd    = pc_fd + PC_STEP;

endmodule

// File: tb/tb_fetch_buf.sv
// tb_fetch_buf
// Self-checking bench for fetch_buf. The bench plays instruction memory
// (content is a fixed function of the address, latency chosen per request)
// and keeps a transaction-level picture of the stage: the expected PC, the
// one outstanding memory request and whether it has been made stale by a
// redirect or reset, and a queue of the instructions decode should see.
module tb_fetch_buf;

    typedef struct {
        logic [15:0] pc;
        logic [15:0] instr;
    } entry_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        halt_df = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [15:0] redirect_pc = 16'h0000;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [15:0] imem_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [15:0] imem_rsp_data = 16'h0000;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [15:0] instr_fd;
    logic [15:0] pc_fd;
    logic [15:0] pcinc_fd;

    int          passCount = 0;
    int          checkCount = 0;

    entry_t      modelQ[$];
    logic [15:0] modelPc = 16'h0000;
    bit          memBusy = 1'b0;
    bit          memStale = 1'b0;
    logic [15:0] memAddr = 16'h0000;
    int          memWait = 0;
    int          latMin = 1;
    int          latMax = 1;
    bit          redirFired = 1'b0;

    fetch_buf #(
        .ADDR_W   (16),
        .INSTR_W  (16),
        .PC_INC   (2),
        .RESET_PC (0),
        .DEPTH    (4)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .halt_df        (halt_df),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr_fd       (instr_fd),
        .pc_fd          (pc_fd),
        .pcinc_fd       (pcinc_fd)
    );

    always #5 clk = ~clk;

    // Instruction memory contents: a scrambled function of the address.
    function automatic logic [15:0] memFn(input logic [15:0] a);
        logic [15:0] prod;
        prod = a * 16'h9E37;
        return prod ^ 16'h5A5A;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) begin
            passCount++;
        end else begin
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // One clock cycle, entered and left at a falling edge. Outputs registered
    // by the previous edge are checked first, then this cycle's inputs are
    // driven, the combinational request is checked, and after the rising
    // edge the reference picture is advanced.
    task automatic applyStimulus(input bit h, input bit r, input logic [15:0] rpc,
                                 input bit qrdy, input bit irdy,
                                 input bit redirOnRsp, input bit stray);
        bit          rspNow;
        bit          expReq;
        bit          accept;
        bit          pop;
        bit          redir;
        entry_t      e;
        logic [15:0] incPc;

        checkOutput("instr_valid", 32'(instr_valid), 32'(modelQ.size() != 0));
        if (modelQ.size() != 0) begin
            incPc = modelQ[0].pc + 16'd2;
            checkOutput("pc_fd", 32'(pc_fd), 32'(modelQ[0].pc));
            checkOutput("instr_fd", 32'(instr_fd), 32'(modelQ[0].instr));
            checkOutput("pcinc_fd", 32'(pcinc_fd), 32'(incPc));
        end

        rspNow         = memBusy && (memWait == 0);
        imem_rsp_valid = rspNow || (stray && !memBusy);
        imem_rsp_data  = rspNow ? memFn(memAddr) : 16'($urandom);
        redir          = r || (redirOnRsp && rspNow);
        if (redir) begin
            redirFired = 1'b1;
        end
        halt_df        = h;
        redirect_valid = redir;
        redirect_pc    = rpc;
        imem_req_ready = qrdy;
        instr_ready    = irdy;
        #1;

        expReq = !memBusy && !h && !redir && (modelQ.size() < 4);
        checkOutput("imem_req_valid", 32'(imem_req_valid), 32'(expReq));
        if (expReq) begin
            checkOutput("imem_addr", 32'(imem_addr), 32'(modelPc));
        end
        accept = expReq && qrdy;
        pop    = (modelQ.size() != 0) && irdy;

        @(posedge clk);

        if (rspNow) begin
            if (!redir && !memStale) begin
                e.pc    = memAddr;
                e.instr = memFn(memAddr);
            end
            memBusy = 1'b0;
        end else if (memBusy) begin
            memWait--;
        end

        if (redir) begin
            modelQ.delete();
            modelPc = rpc;
            if (memBusy) begin
                memStale = 1'b1;
            end
        end else begin
            if (pop) begin
                void'(modelQ.pop_front());
            end
            if (rspNow && !memStale) begin
                modelQ.push_back(e);
            end
        end
        if (rspNow) begin
            memStale = 1'b0;
        end

        if (accept) begin
            memBusy  = 1'b1;
            memStale = 1'b0;
            memAddr  = modelPc;
            modelPc  = modelPc + 16'd2;
            memWait  = int'($urandom_range(latMax, latMin)) - 1;
        end

        @(negedge clk);
    endtask

    // Asynchronous reset pulse, entered and left at a falling edge. A request
    // outstanding at this point is forgotten: its response must be ignored.
    task automatic doReset();
        rst            = 1'b1;
        halt_df        = 1'b0;
        redirect_valid = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        instr_ready    = 1'b0;
        #1;
        checkOutput("rst_instr_valid", 32'(instr_valid), 32'd0);
        checkOutput("rst_req_valid", 32'(imem_req_valid), 32'd0);
        modelQ.delete();
        modelPc  = 16'h0000;
        memBusy  = 1'b0;
        memStale = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        $display("[TB] tb_fetch_buf start");
        doReset();

        // Single-cycle memory, decode always ready.
        latMin = 1; latMax = 1;
        repeat (10) applyStimulus(0, 0, 16'h0, 1, 1, 0, 0);

        // Decode stalls: the queue fills to four and issue stops, then drains.
        repeat (20) applyStimulus(0, 0, 16'h0, 1, 0, 0, 0);
        repeat (12) applyStimulus(0, 0, 16'h0, 1, 1, 0, 0);

        // Redirect while a 3-cycle request is outstanding.
        latMin = 3; latMax = 3;
        for (int i = 0; i < 10 && !memBusy; i++) applyStimulus(0, 0, 16'h0, 1, 1, 0, 0);
        checkOutput("wait_accept_a", 32'(memBusy), 32'd1);
        applyStimulus(0, 1, 16'h0100, 1, 1, 0, 0);
        repeat (15) applyStimulus(0, 0, 16'h0, 1, 1, 0, 0);

        // Redirect in the same cycle as the response.
        latMin = 2; latMax = 2;
        redirFired = 1'b0;
        for (int i = 0; i < 12 && !redirFired; i++) applyStimulus(0, 0, 16'h0200, 1, 1, 1, 0);
        checkOutput("redirect_on_rsp", 32'(redirFired), 32'd1);
        repeat (10) applyStimulus(0, 0, 16'h0, 1, 1, 0, 0);

        // Halt while a request is outstanding.
        latMin = 3; latMax = 3;
        for (int i = 0; i < 10 && !memBusy; i++) applyStimulus(0, 0, 16'h0, 1, 1, 0, 0);
        checkOutput("wait_accept_b", 32'(memBusy), 32'd1);
        repeat (8) applyStimulus(1, 0, 16'h0, 1, 1, 0, 0);
        repeat (8) applyStimulus(0, 0, 16'h0, 1, 1, 0, 0);

        // PC wrap-around at the top of the address space.
        latMin = 1; latMax = 1;
        applyStimulus(0, 1, 16'hFFFE, 1, 1, 0, 0);
        repeat (8) applyStimulus(0, 0, 16'h0, 1, 1, 0, 0);

        // Reset in the middle of an outstanding request; the late response
        // shows up in the first cycle after reset and must be ignored.
        latMin = 3; latMax = 3;
        for (int i = 0; i < 10 && !memBusy; i++) applyStimulus(0, 0, 16'h0, 1, 1, 0, 0);
        checkOutput("wait_accept_c", 32'(memBusy), 32'd1);
        doReset();
        applyStimulus(0, 0, 16'h0, 0, 1, 0, 1);
        latMin = 1; latMax = 1;
        repeat (10) applyStimulus(0, 0, 16'h0, 1, 1, 0, 0);

        // Randomized traffic.
        latMin = 1; latMax = 4;
        for (int i = 0; i < 2000; i++) begin
            logic [15:0] target;
            target = 16'($urandom) & 16'hFFFE;
            if (($urandom % 8) == 0) begin
                target = 16'hFFFE;
            end
            applyStimulus(($urandom % 10) == 0, ($urandom % 16) == 0, target,
                          ($urandom % 4) != 0, ($urandom % 3) != 0,
                          ($urandom % 20) == 0, ($urandom % 10) == 0);
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/fetch_buf.md
# fetch_buf

Parametrised, buffered instruction-fetch stage: drives a PC register and a decoupled instruction-memory request/response port, and delivers fetched instructions through a DEPTH-entry queue to decode over a valid/ready handshake. Supports control-flow redirect with flush and drop of in-flight responses, halt, and variable memory latency. Sits between the PC-select logic of execute/branch resolution and the decode stage, replacing the single-cycle fetch stage.

## Interface
- ADDR_W, 16, PC/address width
- INSTR_W, 16, instruction width
- PC_INC, 2, sequential PC increment in bytes
- RESET_PC, 0, PC value after reset
- DEPTH, 4, queue entries (power of two, ≥2)

- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- halt_df  in  1  stop issuing new fetches; queue still drains
- redirect_valid  in  1  redirect PC, flush queue
- redirect_pc  in  ADDR_W  redirect target
- imem_req_valid  out  1  memory request
- imem_req_ready  in  1  memory accepts request
- imem_addr  out  ADDR_W  request address (current PC)
- imem_rsp_valid  in  1  response data valid (in order, ≥1 cycle after accept)
- imem_rsp_data  in  INSTR_W  fetched instruction
- instr_valid  out  1  queue head valid
- instr_ready  in  1  decode consumes head
- instr_fd  out  INSTR_W  head instruction
- pc_fd  out  ADDR_W  head instruction address
- pcinc_fd  out  ADDR_W  pc_fd + PC_INC

## Operation
- At most one outstanding memory request. States: IDLE (none outstanding), WAIT (outstanding, response kept), DROP (outstanding, response discarded).
- imem_req_valid = (state==IDLE) & ~halt_df & ~redirect_valid & (count < DEPTH); imem_addr = pc.
- Accept (req_valid & req_ready): IDLE→WAIT; pc ← pc + PC_INC (mod 2^ADDR_W); entry tag pc_old carried in a pending-PC register.
- WAIT + rsp_valid: push {rsp_data, pending_pc} into queue; →IDLE. Same-cycle new request impossible (issue only from IDLE).
- DROP + rsp_valid: discard; →IDLE.
- rsp_valid in IDLE: ignored (covers post-reset stragglers).
- Redirect: pc ← redirect_pc; queue flushed (count ← 0); WAIT→DROP; DROP stays DROP; IDLE stays IDLE. Redirect beats a same-cycle response (dropped), pop, and push.
- Pop: instr_valid & instr_ready removes head. Push and pop in the same cycle keep count unchanged.
- Credit rule (count < DEPTH at issue, one outstanding) guarantees the queue never overflows; push with full queue is an assertion failure.
- halt_df only gates new issue; an outstanding request completes and is enqueued normally.
- Arithmetic: all PC adds are modulo 2^ADDR_W; 0xFFFE + 2 → 0x0000 for ADDR_W=16.

## Timing
- Reset (asynchronous): pc = RESET_PC, state = IDLE, count = 0, instr_valid = 0, imem_req_valid = 0 while rst high; instr_fd/pc_fd/pcinc_fd unspecified while instr_valid = 0.
- First request asserted in the first cycle after rst deasserts (halt_df = 0).
- Latency: response in cycle N → instr_valid in cycle N+1 (queue empty case).
- Sustained throughput: one instruction per (memory latency + 1) cycles.
- imem_req_valid depends combinationally on halt_df, redirect_valid, state, count; all other outputs are registered.
- Redirect in cycle N → new request at redirect_pc no earlier than cycle N+1 (IDLE) or after the dropped response returns (DROP).
- Reset mid-request: state clears; late response ignored; no entry enqueued.

## Structure
- fetch_pkg: state enum (IDLE, WAIT, DROP), default parameter constants.
- Sub-module fetch_fifo: synchronous FIFO, DEPTH × (INSTR_W + ADDR_W), push/pop/flush, count output, async active-high reset.
- Top: state machine, PC register, pending-PC register, increment adder, issue logic.

## Test plan
- Reset, 1-cycle memory, instr_ready=1: addresses 0x0000, 0x0002, 0x0004 issued; instr_fd matches memory, pcinc_fd = pc_fd+2.
- instr_ready=0 for 20 cycles: exactly DEPTH (4) entries enqueued, then imem_req_valid stays 0; release → 4 in-order pops, fetching resumes at 0x0008.
- Redirect to 0x0100 while WAIT with 3-cycle latency: outstanding response dropped, queue empty next cycle, next delivered pc_fd = 0x0100.
- Redirect and rsp_valid same cycle: response not delivered; next delivered instruction from redirect target.
- halt_df asserted during outstanding request: that instruction still delivered, no further requests until halt_df falls.
- Wrap: redirect to 0xFFFE: delivered pc_fd 0xFFFE then 0x0000, pcinc_fd 0x0000 then 0x0002; rst pulsed mid-WAIT → late response ignored, fetch restarts at RESET_PC.
